// File: rtl/mem_responder.sv
// Tagged main-memory responder: grants a tag per accepted load, returns the block after MEM_LATENCY cycles.
// Optional debug outputs (busy tags, outstanding count) are enabled by defining MEM_RESP_DEBUG_EN.
module mem_responder #(
  parameter int MEM_LATENCY     = 4,
  parameter int NUM_TAGS        = 16,
  parameter int MEM_SIZE_BLOCKS = 8192
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [1:0]                  proc2mem_command,
  input  logic [31:0]                 proc2mem_addr,
  input  logic [63:0]                 proc2mem_data,
  output logic [$clog2(NUM_TAGS)-1:0] mem2proc_transaction_tag,
  output logic [63:0]                 mem2proc_data,
  output logic [$clog2(NUM_TAGS)-1:0] mem2proc_data_tag
`ifdef MEM_RESP_DEBUG_EN
  ,
  output logic [NUM_TAGS-1:0]         busy_tags_debug,
  output logic [$clog2(NUM_TAGS):0]   outstanding_count_debug
`endif
);

  localparam int TW = $clog2(NUM_TAGS);
  localparam int IW = $clog2(MEM_SIZE_BLOCKS);
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;

  logic [63:0]   r_mem [MEM_SIZE_BLOCKS];
  logic          r_busy [1:NUM_TAGS-1];
  logic [TW-1:0] r_cnt  [1:NUM_TAGS-1];
  logic [63:0]   r_blk  [1:NUM_TAGS-1];

  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_grant;
  logic          w_load;
  logic          w_store;
  logic          w_due_valid;
  logic [TW-1:0] w_due_tag;
  logic [63:0]   w_due_blk;
  logic          w_unused_addr;

  assign w_idx         = proc2mem_addr[3 +: IW];
  assign w_unused_addr = ^{proc2mem_addr[31:3+IW], proc2mem_addr[2:0]};

  // Lowest-numbered free tag; tag 0 means none free.
  always_comb begin
    w_grant = '0;
    for (int i = NUM_TAGS - 1; i >= 1; i--) begin
      if (!r_busy[i]) w_grant = TW'(i);
    end
  end

  assign w_load  = reset && (proc2mem_command == MEM_LOAD) && (w_grant != '0);
  assign w_store = reset && (proc2mem_command == MEM_STORE);
  assign mem2proc_transaction_tag = w_load ? w_grant : '0;

  // A counter at 1 reaches 0 next cycle, so its block is loaded into the output register now.
  always_comb begin
    w_due_valid = 1'b0;
    w_due_tag   = '0;
    w_due_blk   = '0;
    for (int i = 1; i < NUM_TAGS; i++) begin
      if (r_busy[i] && r_cnt[i] == TW'(1)) begin
        w_due_valid = 1'b1;
        w_due_tag   = TW'(i);
        w_due_blk   = r_blk[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_store) r_mem[w_idx] <= proc2mem_data;
  end

  generate
    for (genvar gi = 1; gi < NUM_TAGS; gi++) begin : g_tag
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_busy[gi] <= 1'b0;
          r_cnt[gi]  <= '0;
        end else if (w_load && w_grant == TW'(gi)) begin
          r_busy[gi] <= 1'b1;
          r_cnt[gi]  <= TW'(MEM_LATENCY - 1);
        end else if (r_busy[gi]) begin
          if (r_cnt[gi] == '0) r_busy[gi] <= 1'b0;
          else                 r_cnt[gi]  <= r_cnt[gi] - TW'(1);
        end
      end

      always_ff @(posedge clock) begin
        if (w_load && w_grant == TW'(gi)) r_blk[gi] <= r_mem[w_idx];
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem2proc_data     <= '0;
      mem2proc_data_tag <= '0;
    end else if (w_due_valid) begin
      mem2proc_data     <= w_due_blk;
      mem2proc_data_tag <= w_due_tag;
    end else if (MEM_LATENCY == 1 && w_load) begin
      mem2proc_data     <= r_mem[w_idx];
      mem2proc_data_tag <= w_grant;
    end else begin
      mem2proc_data     <= '0;
      mem2proc_data_tag <= '0;
    end
  end

`ifdef MEM_RESP_DEBUG_EN
  always_comb begin
    busy_tags_debug         = '0;
    outstanding_count_debug = '0;
    for (int i = 1; i < NUM_TAGS; i++) begin
      busy_tags_debug[i]      = r_busy[i];
      outstanding_count_debug = outstanding_count_debug + (TW + 1)'(r_busy[i]);
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: default instance (16 tags, latency 4) and a small one (4 tags, latency 3).
module tb_mem_responder;

  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_LOAD  = 2'd1;
  localparam logic [1:0] C_STORE = 2'd2;

  localparam logic [63:0] D1 = 64'hDEADBEEF_01234567;
  localparam logic [63:0] A0 = 64'h1111_0000_0000_0000;
  localparam logic [63:0] A1 = 64'h2222_0000_0000_0008;
  localparam logic [63:0] A2 = 64'h3333_0000_0000_0010;
  localparam logic [63:0] VA = 64'hAAAA_AAAA_0000_0200;
  localparam logic [63:0] VB = 64'hBBBB_BBBB_0000_0200;
  localparam logic [63:0] VW = 64'h5A5A_0000_0001_0008;
  localparam logic [63:0] B0 = 64'hC0DE_C0DE_0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  a_cmd, b_cmd;
  logic [31:0] a_addr, b_addr;
  logic [63:0] a_wdata, b_wdata;
  logic [3:0]  a_ttag, a_dtag;
  logic [63:0] a_rdata;
  logic [1:0]  b_ttag, b_dtag;
  logic [63:0] b_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  mem_responder u_a (
    .clock                    (clk),
    .reset                    (rst_n),
    .proc2mem_command         (a_cmd),
    .proc2mem_addr            (a_addr),
    .proc2mem_data            (a_wdata),
    .mem2proc_transaction_tag (a_ttag),
    .mem2proc_data            (a_rdata),
    .mem2proc_data_tag        (a_dtag)
  );

  mem_responder #(.MEM_LATENCY(3), .NUM_TAGS(4), .MEM_SIZE_BLOCKS(8192)) u_b (
    .clock                    (clk),
    .reset                    (rst_n),
    .proc2mem_command         (b_cmd),
    .proc2mem_addr            (b_addr),
    .proc2mem_data            (b_wdata),
    .mem2proc_transaction_tag (b_ttag),
    .mem2proc_data            (b_rdata),
    .mem2proc_data_tag        (b_dtag)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at posedge+1, sample at the following negedge, return at next posedge+1.
  task automatic run(input int inst, input logic [1:0] cmd, input logic [31:0] addr,
                     input logic [63:0] wd, input int et, input int ed,
                     input logic [63:0] edata, input string name);
    a_cmd = C_NONE; a_addr = '0; a_wdata = '0;
    b_cmd = C_NONE; b_addr = '0; b_wdata = '0;
    if (inst == 0) begin
      a_cmd = cmd; a_addr = addr; a_wdata = wd;
    end else begin
      b_cmd = cmd; b_addr = addr; b_wdata = wd;
    end
    @(negedge clk);
    if (inst == 0) begin
      chk({name, ".ttag"}, 64'(a_ttag), 64'(et));
      chk({name, ".dtag"}, 64'(a_dtag), 64'(ed));
      chk({name, ".data"}, a_rdata, edata);
      $display("[%0t] %s A cmd=%0d addr=%h ttag=%0d dtag=%0d data=%h",
               $time, name, cmd, addr, a_ttag, a_dtag, a_rdata);
    end else begin
      chk({name, ".ttag"}, 64'(b_ttag), 64'(et));
      chk({name, ".dtag"}, 64'(b_dtag), 64'(ed));
      chk({name, ".data"}, b_rdata, edata);
      $display("[%0t] %s B cmd=%0d addr=%h ttag=%0d dtag=%0d data=%h",
               $time, name, cmd, addr, b_ttag, b_dtag, b_rdata);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    a_cmd = C_LOAD; a_addr = '0; a_wdata = '0;
    b_cmd = C_LOAD; b_addr = '0; b_wdata = '0;
    #12;
    chk("rst.a_ttag", 64'(a_ttag), 64'd0);
    chk("rst.a_dtag", 64'(a_dtag), 64'd0);
    chk("rst.a_data", a_rdata, 64'd0);
    chk("rst.b_ttag", 64'(b_ttag), 64'd0);
    chk("rst.b_dtag", 64'(b_dtag), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Store then load of the same block at a different byte offset
    run(0, C_STORE, 32'h100, D1, 0, 0, 0, "t1.st");
    run(0, C_LOAD,  32'h104, 0,  1, 0, 0, "t1.ld");
    run(0, C_NONE, 0, 0, 0, 0, 0, "t1.w2");
    run(0, C_NONE, 0, 0, 0, 0, 0, "t1.w3");
    run(0, C_NONE, 0, 0, 0, 0, 0, "t1.w4");
    run(0, C_NONE, 0, 0, 0, 1, D1, "t1.rsp");
    run(0, C_NONE, 0, 0, 0, 0, 0, "t1.w6");

    // Back-to-back loads
    run(0, C_STORE, 32'h0,  A0, 0, 0, 0, "t2.st0");
    run(0, C_STORE, 32'h8,  A1, 0, 0, 0, "t2.st1");
    run(0, C_STORE, 32'h10, A2, 0, 0, 0, "t2.st2");
    run(0, C_LOAD,  32'h0,  0, 1, 0, 0, "t2.ld0");
    run(0, C_LOAD,  32'h8,  0, 2, 0, 0, "t2.ld1");
    run(0, C_LOAD,  32'h10, 0, 3, 0, 0, "t2.ld2");
    run(0, C_NONE, 0, 0, 0, 0, 0,  "t2.w3");
    run(0, C_NONE, 0, 0, 0, 1, A0, "t2.rsp1");
    run(0, C_NONE, 0, 0, 0, 2, A1, "t2.rsp2");
    run(0, C_NONE, 0, 0, 0, 3, A2, "t2.rsp3");
    run(0, C_NONE, 0, 0, 0, 0, 0,  "t2.w7");

    // Store behind a pending load does not alter that load's data
    run(0, C_STORE, 32'h200, VA, 0, 0, 0, "t4.stA");
    run(0, C_LOAD,  32'h200, 0,  1, 0, 0, "t4.ld1");
    run(0, C_STORE, 32'h200, VB, 0, 0, 0, "t4.stB");
    run(0, C_LOAD,  32'h200, 0,  2, 0, 0, "t4.ld2");
    run(0, C_NONE, 0, 0, 0, 0, 0,  "t4.w3");
    run(0, C_NONE, 0, 0, 0, 1, VA, "t4.rsp1");
    run(0, C_NONE, 0, 0, 0, 0, 0,  "t4.w5");
    run(0, C_NONE, 0, 0, 0, 2, VB, "t4.rsp2");
    run(0, C_NONE, 0, 0, 0, 0, 0,  "t4.w7");

    // Address wrap: 0x8 + 8*8192 aliases block 1
    run(0, C_STORE, 32'h10008, VW, 0, 0, 0, "t6.st");
    run(0, C_LOAD,  32'h8,     0,  1, 0, 0, "t6.ld");
    run(0, C_NONE, 0, 0, 0, 0, 0,  "t6.w2");
    run(0, C_NONE, 0, 0, 0, 0, 0,  "t6.w3");
    run(0, C_NONE, 0, 0, 0, 0, 0,  "t6.w4");
    run(0, C_NONE, 0, 0, 0, 1, VW, "t6.rsp");

    // Reset with two loads pending
    run(0, C_LOAD, 32'h100, 0, 1, 0, 0, "t5.ld1");
    run(0, C_LOAD, 32'h0,   0, 2, 0, 0, "t5.ld2");
    run(0, C_NONE, 0, 0, 0, 0, 0, "t5.w2");
    run(0, C_NONE, 0, 0, 0, 0, 0, "t5.w3");
    a_cmd = C_NONE;
    #2;
    chk("t5.pre_dtag", 64'(a_dtag), 64'd1);
    chk("t5.pre_data", a_rdata, D1);
    rst_n = 1'b0;
    #1;
    chk("t5.rst_dtag", 64'(a_dtag), 64'd0);
    chk("t5.rst_data", a_rdata, 64'd0);
    a_cmd = C_LOAD;
    #1;
    chk("t5.rst_ttag", 64'(a_ttag), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) run(0, C_NONE, 0, 0, 0, 0, 0, "t5.idle");
    run(0, C_LOAD, 32'h100, 0, 1, 0, 0, "t5.ld3");
    run(0, C_NONE, 0, 0, 0, 0, 0, "t5.w1");
    run(0, C_NONE, 0, 0, 0, 0, 0, "t5.w2b");
    run(0, C_NONE, 0, 0, 0, 0, 0, "t5.w3b");
    run(0, C_NONE, 0, 0, 0, 1, D1, "t5.rsp");
    run(0, C_NONE, 0, 0, 0, 0, 0, "t5.w5");

    // Small instance: tag exhaustion and reuse timing
    run(1, C_STORE, 32'h0, B0, 0, 0, 0, "t3.st");
    run(1, C_LOAD, 32'h0, 0, 1, 0, 0,  "t3.c0");
    run(1, C_LOAD, 32'h0, 0, 2, 0, 0,  "t3.c1");
    run(1, C_LOAD, 32'h0, 0, 3, 0, 0,  "t3.c2");
    run(1, C_LOAD, 32'h0, 0, 0, 1, B0, "t3.c3");
    run(1, C_LOAD, 32'h0, 0, 1, 2, B0, "t3.c4");
    run(1, C_LOAD, 32'h0, 0, 2, 3, B0, "t3.c5");
    run(1, C_LOAD, 32'h0, 0, 3, 0, 0,  "t3.c6");
    run(1, C_LOAD, 32'h0, 0, 0, 1, B0, "t3.c7");
    run(1, C_NONE, 0, 0, 0, 2, B0, "t3.c8");
    run(1, C_NONE, 0, 0, 0, 3, B0, "t3.c9");
    run(1, C_NONE, 0, 0, 0, 0, 0,  "t3.c10");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
